maquina_cafe_param: RTL and testbench
=====================================

MAQUINA_CAFE_PARAM -- requirements
Module: maquina_cafe_param

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- GRIND_CYCLES, 3, cycles spent in MOER_CAFE (1..2^TMR_W-1)
- EXTRACT_CYCLES, 4, cycles spent in REALIZAR_EXTRACAO per cup (1..2^TMR_W-1)
- FILL_TIMEOUT, 8, max cycles in ENCHER_RESERVATORIO before error (1..2^TMR_W-1)
- CUP_W, 3, width of cup count fields
- TMR_W, 8, width of internal step timer
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request brew; sampled only in IDLE
- cups  in  CUP_W  cups to brew; latched on accepted start
- agua_ok  in  1  water level sensor, 1 = reservoir full
- abort  in  1  cancel current job / clear error
- state  out  4  current state code
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- cups_done  out  CUP_W  cups finished in current/last job
- error  out  1  fill-timeout error flag

Function
REQ-003 State codes SHALL be: IDLE=1, LIGAR_MAQUINA=2, VERIFICAR_AGUA=3, ENCHER_RESERVATORIO=4, MOER_CAFE=5, COLOCAR_NO_FILTRO=6, PASSAR_AGITADOR=7, TAMPEAR=8, REALIZAR_EXTRACAO=9, ERRO=10; state output is the registered state.
REQ-004 IDLE: start=1 -> LIGAR_MAQUINA next cycle; target latched = cups, cups=0 treated as 1; cups_done cleared to 0; start=0 -> stay.
REQ-005 LIGAR_MAQUINA: one cycle, -> VERIFICAR_AGUA.
REQ-006 VERIFICAR_AGUA: one cycle; agua_ok=1 -> MOER_CAFE, agua_ok=0 -> ENCHER_RESERVATORIO.
REQ-007 ENCHER_RESERVATORIO: agua_ok=1 -> VERIFICAR_AGUA; agua_ok=0 for FILL_TIMEOUT consecutive cycles in this state -> ERRO; timer cleared on entry.
REQ-008 MOER_CAFE: exactly GRIND_CYCLES cycles, then -> COLOCAR_NO_FILTRO.
REQ-009 COLOCAR_NO_FILTRO -> PASSAR_AGITADOR -> TAMPEAR -> REALIZAR_EXTRACAO, one cycle each.
REQ-010 REALIZAR_EXTRACAO: exactly EXTRACT_CYCLES cycles; on final cycle cups_done increments; if new cups_done == target -> IDLE, else -> VERIFICAR_AGUA (next cup).
REQ-011 done SHALL be 1 only during the first IDLE cycle after a completed job; never after abort or error.
REQ-012 ERRO: error=1 while in ERRO; leaves only on abort=1 -> IDLE; start ignored.
REQ-013 abort=1 in any non-IDLE state -> IDLE next cycle, overriding all other transitions; cups_done holds its value; abort in IDLE has no effect.
REQ-014 busy SHALL be 1 in states 2..9, 0 in IDLE and ERRO.
REQ-015 start outside IDLE SHALL be ignored; start still high on return to IDLE starts a new job on that cycle's edge.
REQ-016 Unused state codes (0, 11..15) SHALL go to IDLE next cycle.
REQ-017 cups_done SHALL not wrap: target <= 2^CUP_W-1 guarantees termination.

Reset
REQ-018 rst=1 at a clock edge SHALL force state=IDLE, busy=0, done=0, cups_done=0, error=0, timer=0, target=0, from any state including mid-extraction and ERRO; rst has priority over abort and start.

Verification
REQ-019 Defaults except GRIND_CYCLES=1, EXTRACT_CYCLES=1; cups=1, agua_ok=0 until ENCHER entered then 1, start high 2 cycles -> states 1,2,3,4,3,5,6,7,8,9,1, done=1 on final IDLE, cups_done=1.
REQ-020 Defaults, cups=2, agua_ok=1 -> 2,3,5x3,6,7,8,9x4,3,5x3,6,7,8,9x4,1; cups_done 1 then 2; done one cycle.
REQ-021 agua_ok held 0 -> ENCHER for 8 cycles then ERRO, error=1, busy=0; start ignored; abort pulse -> IDLE, error=0, done=0.
REQ-022 abort pulse during 2nd MOER_CAFE of cups=3 job -> IDLE next cycle, cups_done=1, done never asserted.
REQ-023 rst pulse during REALIZAR_EXTRACAO and during ERRO -> next cycle all outputs at reset values, state=1.

Source files
------------

// File: rtl/maquina_cafe_param.sv
// Coffee machine sequencer: power-on, water check/refill, grind, tamp, per-cup extraction.
// Registered state, one transition per clock; no backpressure (abort cancels, fill timeout parks in ERRO).
module maquina_cafe_param #(
    parameter int GRIND_CYCLES   = 3,
    parameter int EXTRACT_CYCLES = 4,
    parameter int FILL_TIMEOUT   = 8,
    parameter int CUP_W          = 3,
    parameter int TMR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CUP_W-1:0] cups,
    input  logic             agua_ok,
    input  logic             abort,
    output logic [3:0]       state,
    output logic             busy,
    output logic             done,
    output logic [CUP_W-1:0] cups_done,
    output logic             error
);

    typedef enum logic [3:0] {
        IDLE                = 4'd1,
        LIGAR_MAQUINA       = 4'd2,
        VERIFICAR_AGUA      = 4'd3,
        ENCHER_RESERVATORIO = 4'd4,
        MOER_CAFE           = 4'd5,
        COLOCAR_NO_FILTRO   = 4'd6,
        PASSAR_AGITADOR     = 4'd7,
        TAMPEAR             = 4'd8,
        REALIZAR_EXTRACAO   = 4'd9,
        ERRO                = 4'd10
    } state_t;

    localparam logic [TMR_W-1:0] GRIND_LAST   = TMR_W'(GRIND_CYCLES - 1);
    localparam logic [TMR_W-1:0] EXTRACT_LAST = TMR_W'(EXTRACT_CYCLES - 1);
    localparam logic [TMR_W-1:0] FILL_LAST    = TMR_W'(FILL_TIMEOUT - 1);

    state_t           cur_state;
    state_t           next_state;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic [CUP_W-1:0] target;
    logic [CUP_W-1:0] target_nxt;
    logic [CUP_W-1:0] cups_done_nxt;
    logic             done_nxt;

    always_comb begin
        next_state    = cur_state;
        target_nxt    = target;
        cups_done_nxt = cups_done;
        done_nxt      = 1'b0;
        if (abort && cur_state != IDLE) begin
            next_state = IDLE;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        next_state    = LIGAR_MAQUINA;
                        target_nxt    = (cups == '0) ? CUP_W'(1) : cups;
                        cups_done_nxt = '0;
                    end
                end
                LIGAR_MAQUINA:  next_state = VERIFICAR_AGUA;
                VERIFICAR_AGUA: next_state = agua_ok ? MOER_CAFE : ENCHER_RESERVATORIO;
                ENCHER_RESERVATORIO: begin
                    if (agua_ok)
                        next_state = VERIFICAR_AGUA;
                    else if (timer == FILL_LAST)
                        next_state = ERRO;
                end
                MOER_CAFE: begin
                    if (timer == GRIND_LAST)
                        next_state = COLOCAR_NO_FILTRO;
                end
                COLOCAR_NO_FILTRO: next_state = PASSAR_AGITADOR;
                PASSAR_AGITADOR:   next_state = TAMPEAR;
                TAMPEAR:           next_state = REALIZAR_EXTRACAO;
                REALIZAR_EXTRACAO: begin
                    if (timer == EXTRACT_LAST) begin
                        cups_done_nxt = cups_done + CUP_W'(1);
                        if (cups_done_nxt == target) begin
                            next_state = IDLE;
                            done_nxt   = 1'b1;
                        end else begin
                            next_state = VERIFICAR_AGUA;
                        end
                    end
                end
                ERRO:    next_state = ERRO;
                default: next_state = IDLE;
            endcase
        end
        // Timer measures cycles spent in the current state; any state change restarts it.
        timer_nxt = (next_state == cur_state) ? timer + TMR_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            timer     <= '0;
            target    <= '0;
            cups_done <= '0;
            done      <= 1'b0;
        end else begin
            cur_state <= next_state;
            timer     <= timer_nxt;
            target    <= target_nxt;
            cups_done <= cups_done_nxt;
            done      <= done_nxt;
        end
    end

    assign state = cur_state;
    assign busy  = (cur_state >= LIGAR_MAQUINA) && (cur_state <= REALIZAR_EXTRACAO);
    assign error = (cur_state == ERRO);

endmodule

// File: tb/tb_maquina_cafe_param.sv
// Bench for maquina_cafe_param: two instances (default timing and 1-cycle grind/extract)
// share stimulus; directed scenarios plus random traffic against a cycle reference model.
module tb_maquina_cafe_param;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] cups;
    logic       agua_ok;
    logic       abort;

    logic [3:0] state_a, state_b;
    logic       busy_a, busy_b, done_a, done_b, error_a, error_b;
    logic [2:0] cups_done_a, cups_done_b;

    int n_tests = 0;
    int n_fail  = 0;

    maquina_cafe_param dut_a (
        .clk(clk), .rst(rst), .start(start), .cups(cups), .agua_ok(agua_ok), .abort(abort),
        .state(state_a), .busy(busy_a), .done(done_a), .cups_done(cups_done_a), .error(error_a)
    );

    maquina_cafe_param #(.GRIND_CYCLES(1), .EXTRACT_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .cups(cups), .agua_ok(agua_ok), .abort(abort),
        .state(state_b), .busy(busy_b), .done(done_b), .cups_done(cups_done_b), .error(error_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: phase number, cycles already spent in it, cup goal and cups brewed.
    typedef struct packed {
        int st;
        int dwell;
        int target;
        int cd;
        bit dn;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_next(input mdl_t m, input int grind, input int extract,
                                      input bit s, input int c, input bit a, input bit ab,
                                      input bit r);
        mdl_t n;
        n    = m;
        n.dn = 1'b0;
        if (r) begin
            n.st = 1; n.dwell = 0; n.target = 0; n.cd = 0;
            return n;
        end
        if (ab && m.st != 1) begin
            n.st = 1;
        end else begin
            case (m.st)
                1: if (s) begin
                       n.st = 2;
                       n.target = (c == 0) ? 1 : c;
                       n.cd = 0;
                   end
                2: n.st = 3;
                3: n.st = a ? 5 : 4;
                4: n.st = a ? 3 : ((m.dwell + 1 >= 8) ? 10 : 4);
                5: n.st = (m.dwell + 1 >= grind) ? 6 : 5;
                6: n.st = 7;
                7: n.st = 8;
                8: n.st = 9;
                9: if (m.dwell + 1 >= extract) begin
                       n.cd = m.cd + 1;
                       if (n.cd == m.target) begin
                           n.st = 1;
                           n.dn = 1'b1;
                       end else begin
                           n.st = 3;
                       end
                   end
                10: n.st = 10;
                default: n.st = 1;
            endcase
        end
        n.dwell = (n.st == m.st) ? m.dwell + 1 : 0;
        return n;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("a_state", int'(state_a), ma.st);
        chk("a_busy", int'(busy_a), int'(ma.st >= 2 && ma.st <= 9));
        chk("a_done", int'(done_a), int'(ma.dn));
        chk("a_cups_done", int'(cups_done_a), ma.cd);
        chk("a_error", int'(error_a), int'(ma.st == 10));
        chk("b_state", int'(state_b), mb.st);
        chk("b_busy", int'(busy_b), int'(mb.st >= 2 && mb.st <= 9));
        chk("b_done", int'(done_b), int'(mb.dn));
        chk("b_cups_done", int'(cups_done_b), mb.cd);
        chk("b_error", int'(error_b), int'(mb.st == 10));
    endtask

    task automatic step();
        @(posedge clk);
        ma = mdl_next(ma, 3, 4, start, int'(cups), agua_ok, abort, rst);
        mb = mdl_next(mb, 1, 1, start, int'(cups), agua_ok, abort, rst);
        #1;
        cmp_all();
    endtask

    task automatic rst_pulse();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        step();
        rst = 1'b0;
    endtask

    int seq_b[10];
    int seq_a[$];
    int done_cnt;

    initial begin
        ma = '0; mb = '0;
        rst = 1'b1; start = 1'b0; cups = 3'd1; agua_ok = 1'b0; abort = 1'b0;

        // Reset state
        rst_pulse();
        chk("rst_state", int'(state_a), 1);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_cups_done", int'(cups_done_a), 0);

        // Short-timing job with a refill detour
        seq_b = '{2, 3, 4, 3, 5, 6, 7, 8, 9, 1};
        cups = 3'd1; agua_ok = 1'b0; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("b_seq", int'(state_b), seq_b[i]);
            if (i == 1) start = 1'b0;
            if (i == 2) agua_ok = 1'b1;
        end
        chk("b_final_done", int'(done_b), 1);
        chk("b_final_cups", int'(cups_done_b), 1);

        // Two cups at default timing
        rst_pulse();
        seq_a.delete();
        seq_a.push_back(2);
        for (int c = 0; c < 2; c++) begin
            seq_a.push_back(3);
            for (int k = 0; k < 3; k++) seq_a.push_back(5);
            seq_a.push_back(6); seq_a.push_back(7); seq_a.push_back(8);
            for (int k = 0; k < 4; k++) seq_a.push_back(9);
        end
        seq_a.push_back(1);
        cups = 3'd2; agua_ok = 1'b1; start = 1'b1; done_cnt = 0;
        for (int i = 0; i < seq_a.size(); i++) begin
            step();
            start = 1'b0;
            chk("a_seq", int'(state_a), seq_a[i]);
            if (i == 12) chk("a_mid_cups", int'(cups_done_a), 1);
            if (done_a) done_cnt++;
        end
        step();
        if (done_a) done_cnt++;
        chk("a_done_pulses", done_cnt, 1);
        chk("a_final_cups", int'(cups_done_a), 2);

        // Fill timeout, error parking, abort recovery
        rst_pulse();
        cups = 3'd1; agua_ok = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("fill_state", int'(state_a), 4);
        end
        step();
        chk("err_state", int'(state_a), 10);
        chk("err_flag", int'(error_a), 1);
        chk("err_busy", int'(busy_a), 0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("err_hold", int'(state_a), 10);
        end
        start = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_err_state", int'(state_a), 1);
        chk("abort_err_flag", int'(error_a), 0);
        chk("abort_err_done", int'(done_a), 0);

        // Abort during second grind of a three-cup job
        rst_pulse();
        cups = 3'd3; agua_ok = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 13; i++) step();
        chk("pre_abort_state", int'(state_a), 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", int'(state_a), 1);
        chk("abort_cups", int'(cups_done_a), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", int'(done_a), 0);
        end

        // Reset mid-extraction, then reset from ERRO
        cups = 3'd1; agua_ok = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("pre_rst_extract", int'(state_a), 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_x_state", int'(state_a), 1);
        chk("rst_x_busy", int'(busy_a), 0);
        chk("rst_x_cups", int'(cups_done_a), 0);
        agua_ok = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("pre_rst_err", int'(state_a), 10);
        rst = 1'b1; abort = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        chk("rst_e_state", int'(state_a), 1);
        chk("rst_e_error", int'(error_a), 0);
        chk("rst_e_done", int'(done_a), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 9) < 3);
            abort = ($urandom_range(0, 99) < 2);
            rst   = ($urandom_range(0, 299) == 0);
            cups  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) agua_ok = ~agua_ok;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
